// File: rtl/pipeline_hazard_controller_if.sv
// Handshake bundle between the ID/EX datapath and the hazard controller.
// master = datapath side, slave = hazard controller.
interface pipeline_hazard_controller_if #(
  parameter int REG_AW = 3
);
  logic [REG_AW-1:0] ID_Rs1;
  logic [REG_AW-1:0] ID_Rs2;
  logic [REG_AW-1:0] ID_Rd;
  logic              ID_Valid;
  logic              ID_RegWrite;
  logic              ID_MemRead;
  logic              Branch_Taken;
  logic              Mem_Ready;
  logic              Stall;
  logic              Flush_ID;
  logic              Freeze;
  logic [1:0]        Forward_A;
  logic [1:0]        Forward_B;
  logic [15:0]       Stall_Cycles;

  modport master (
    output ID_Rs1, ID_Rs2, ID_Rd,
    output ID_Valid, ID_RegWrite, ID_MemRead,
    output Branch_Taken, Mem_Ready,
    input  Stall, Flush_ID, Freeze,
    input  Forward_A, Forward_B, Stall_Cycles
  );

  modport slave (
    input  ID_Rs1, ID_Rs2, ID_Rd,
    input  ID_Valid, ID_RegWrite, ID_MemRead,
    input  Branch_Taken, Mem_Ready,
    output Stall, Flush_ID, Freeze,
    output Forward_A, Forward_B, Stall_Cycles
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Hazard unit: load-use/RAW stall, MEM-wait freeze, branch flush, EX forwarding.
// Define FORWARDING_EN for forwarding; otherwise every RAW hazard stalls.
module pipeline_hazard_controller #(
  parameter int REG_AW = 3
) (
  input logic clk,
  input logic reset,
  pipeline_hazard_controller_if.slave hz
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              mr;
  } stage_t;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  stage_t      ex_q, mem_q, wb_q, ex_d;
  state_t      state_q, state_d;
  logic [1:0]  fwd_a_q, fwd_a_d;
  logic [1:0]  fwd_b_q, fwd_b_d;
  logic [15:0] cnt_q, cnt_d;

  logic ex_wr, mem_wr, mem_load, frz;
  logic a_ex, b_ex, a_mem, b_mem;
  logic raw, stall, flush, enter;

  assign ex_wr  = ex_q.valid & ex_q.rw & (ex_q.rd != '0);
  assign mem_wr = mem_q.valid & mem_q.rw & (mem_q.rd != '0);

  assign a_ex  = ex_wr  & (hz.ID_Rs1 != '0) & (hz.ID_Rs1 == ex_q.rd);
  assign b_ex  = ex_wr  & (hz.ID_Rs2 != '0) & (hz.ID_Rs2 == ex_q.rd);
  assign a_mem = mem_wr & (hz.ID_Rs1 != '0) & (hz.ID_Rs1 == mem_q.rd);
  assign b_mem = mem_wr & (hz.ID_Rs2 != '0) & (hz.ID_Rs2 == mem_q.rd);

  assign mem_load = mem_q.valid & mem_q.mr;
  assign frz = (mem_load | (state_q == MEM_WAIT)) & ~hz.Mem_Ready;

`ifdef FORWARDING_EN
  assign raw = ex_q.mr & (a_ex | b_ex);
`else
  assign raw = a_ex | b_ex | a_mem | b_mem;
`endif

  // Freeze dominates both branch flush and stall
  assign stall = hz.ID_Valid & raw & ~hz.Branch_Taken & ~frz;
  assign flush = hz.Branch_Taken & ~frz;
  assign enter = hz.ID_Valid & ~stall & ~flush;

  assign hz.Stall        = stall;
  assign hz.Flush_ID     = flush;
  assign hz.Freeze       = frz;
  assign hz.Forward_A    = fwd_a_q;
  assign hz.Forward_B    = fwd_b_q;
  assign hz.Stall_Cycles = cnt_q;

  always_comb begin
    ex_d = '0;
    if (enter) begin
      ex_d.valid = 1'b1;
      ex_d.rd    = hz.ID_Rd;
      ex_d.rw    = hz.ID_RegWrite;
      ex_d.mr    = hz.ID_MemRead;
    end
  end

  always_comb begin
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
`ifdef FORWARDING_EN
    if (enter) begin
      if (a_ex)       fwd_a_d = 2'b01;
      else if (a_mem) fwd_a_d = 2'b10;
      if (b_ex)       fwd_b_d = 2'b01;
      else if (b_mem) fwd_b_d = 2'b10;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (mem_load && !hz.Mem_Ready) state_d = MEM_WAIT;
      MEM_WAIT: if (hz.Mem_Ready) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((stall | frz) && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= RUN;
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!frz) begin
        ex_q    <= ex_d;
        mem_q   <= ex_q;
        wb_q    <= mem_q;
        fwd_a_q <= fwd_a_d;
        fwd_b_q <= fwd_b_d;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed scenarios plus random
// stimulus against an in-flight instruction queue model.
module tb_pipeline_hazard_controller;
  localparam int AW = 3;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int tests = 0;
  int fails = 0;

  pipeline_hazard_controller_if #(.REG_AW(AW)) hz ();

  pipeline_hazard_controller #(.REG_AW(AW)) dut (
    .clk(clk),
    .reset(reset),
    .hz(hz)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } rec_t;

  task automatic put(bit v, int rs1, int rs2, int rd, bit rw, bit mr);
    hz.ID_Valid    = v;
    hz.ID_Rs1      = AW'(rs1);
    hz.ID_Rs2      = AW'(rs2);
    hz.ID_Rd       = AW'(rd);
    hz.ID_RegWrite = rw;
    hz.ID_MemRead  = mr;
  endtask

  task automatic idle();
    put(0, 0, 0, 0, 0, 0);
    hz.Branch_Taken = 1'b0;
    hz.Mem_Ready    = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    tests++; if (hz.Stall !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b want 0", hz.Stall); end
    tests++; if (hz.Freeze !== 1'b0) begin fails++; $display("FAIL rst_freeze: got %b want 0", hz.Freeze); end
    tests++; if (hz.Flush_ID !== 1'b0) begin fails++; $display("FAIL rst_flush: got %b want 0", hz.Flush_ID); end
    tests++; if (hz.Forward_A !== 2'b00) begin fails++; $display("FAIL rst_fwda: got %b want 00", hz.Forward_A); end
    tests++; if (hz.Forward_B !== 2'b00) begin fails++; $display("FAIL rst_fwdb: got %b want 00", hz.Forward_B); end
    tests++; if (hz.Stall_Cycles !== 16'd0) begin fails++; $display("FAIL rst_cnt: got %0d want 0", hz.Stall_Cycles); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp1;
    logic [1:0] ea;
    logic [15:0] ec;
    do_reset();
    @(negedge clk); put(1, 1, 2, 3, 1, 0); #1;
    tests++; if (hz.Stall !== 1'b0) begin fails++; $display("FAIL b2b_s1: got %b want 0", hz.Stall); end
    exp1 = FWD ? 1'b0 : 1'b1;
    @(negedge clk); put(1, 3, 1, 4, 1, 0); #1;
    tests++; if (hz.Stall !== exp1) begin fails++; $display("FAIL b2b_s2: got %b want %b", hz.Stall, exp1); end
    @(negedge clk); put(!FWD, 3, 1, 4, 1, 0); #1;
    ea = FWD ? 2'b01 : 2'b00;
    tests++; if (hz.Stall !== exp1) begin fails++; $display("FAIL b2b_s3: got %b want %b", hz.Stall, exp1); end
    tests++; if (hz.Forward_A !== ea) begin fails++; $display("FAIL b2b_fwda: got %b want %b", hz.Forward_A, ea); end
    tests++; if (hz.Forward_B !== 2'b00) begin fails++; $display("FAIL b2b_fwdb: got %b want 00", hz.Forward_B); end
    @(negedge clk); put(!FWD, 3, 1, 4, 1, 0); #1;
    ec = FWD ? 16'd0 : 16'd2;
    tests++; if (hz.Stall !== 1'b0) begin fails++; $display("FAIL b2b_s4: got %b want 0", hz.Stall); end
    tests++; if (hz.Stall_Cycles !== ec) begin fails++; $display("FAIL b2b_cnt: got %0d want %0d", hz.Stall_Cycles, ec); end
  endtask

  task automatic test_load_use();
    logic exp1;
    logic [1:0] ef;
    logic [15:0] ec;
    do_reset();
    @(negedge clk); put(1, 0, 0, 2, 1, 1); #1;
    @(negedge clk); put(1, 2, 2, 5, 1, 0); #1;
    tests++; if (hz.Stall !== 1'b1) begin fails++; $display("FAIL lu_s1: got %b want 1", hz.Stall); end
    exp1 = FWD ? 1'b0 : 1'b1;
    @(negedge clk); put(1, 2, 2, 5, 1, 0); #1;
    tests++; if (hz.Stall !== exp1) begin fails++; $display("FAIL lu_s2: got %b want %b", hz.Stall, exp1); end
    tests++; if (hz.Forward_A !== 2'b00) begin fails++; $display("FAIL lu_bubble: got %b want 00", hz.Forward_A); end
    @(negedge clk); put(!FWD, 2, 2, 5, 1, 0); #1;
    ef = FWD ? 2'b10 : 2'b00;
    ec = FWD ? 16'd1 : 16'd2;
    tests++; if (hz.Stall !== 1'b0) begin fails++; $display("FAIL lu_s3: got %b want 0", hz.Stall); end
    tests++; if (hz.Forward_A !== ef) begin fails++; $display("FAIL lu_fwda: got %b want %b", hz.Forward_A, ef); end
    tests++; if (hz.Forward_B !== ef) begin fails++; $display("FAIL lu_fwdb: got %b want %b", hz.Forward_B, ef); end
    tests++; if (hz.Stall_Cycles !== ec) begin fails++; $display("FAIL lu_cnt: got %0d want %0d", hz.Stall_Cycles, ec); end
  endtask

  task automatic test_mem_wait();
    logic exp1;
    logic [1:0] ef;
    do_reset();
    @(negedge clk); put(1, 0, 0, 2, 1, 1); #1;
    @(negedge clk); put(0, 0, 0, 0, 0, 0); #1;
    @(negedge clk); put(1, 2, 2, 5, 1, 0); hz.Mem_Ready = 1'b0; #1;
    tests++; if (hz.Freeze !== 1'b1) begin fails++; $display("FAIL mw_frz1: got %b want 1", hz.Freeze); end
    tests++; if (hz.Stall !== 1'b0) begin fails++; $display("FAIL mw_stall: got %b want 0", hz.Stall); end
    @(negedge clk); hz.Branch_Taken = 1'b1; #1;
    tests++; if (hz.Freeze !== 1'b1) begin fails++; $display("FAIL mw_frz2: got %b want 1", hz.Freeze); end
    tests++; if (hz.Flush_ID !== 1'b0) begin fails++; $display("FAIL mw_flush: got %b want 0", hz.Flush_ID); end
    @(negedge clk); hz.Branch_Taken = 1'b0; #1;
    tests++; if (hz.Freeze !== 1'b1) begin fails++; $display("FAIL mw_frz3: got %b want 1", hz.Freeze); end
    tests++; if (hz.Stall_Cycles !== 16'd2) begin fails++; $display("FAIL mw_cnt2: got %0d want 2", hz.Stall_Cycles); end
    @(negedge clk); hz.Mem_Ready = 1'b1; #1;
    exp1 = FWD ? 1'b0 : 1'b1;
    tests++; if (hz.Freeze !== 1'b0) begin fails++; $display("FAIL mw_frz4: got %b want 0", hz.Freeze); end
    tests++; if (hz.Stall !== exp1) begin fails++; $display("FAIL mw_s4: got %b want %b", hz.Stall, exp1); end
    tests++; if (hz.Stall_Cycles !== 16'd3) begin fails++; $display("FAIL mw_cnt3: got %0d want 3", hz.Stall_Cycles); end
    @(negedge clk); put(0, 0, 0, 0, 0, 0); #1;
    ef = FWD ? 2'b10 : 2'b00;
    tests++; if (hz.Forward_A !== ef) begin fails++; $display("FAIL mw_fwda: got %b want %b", hz.Forward_A, ef); end
  endtask

  task automatic test_branch_on_stall();
    do_reset();
    @(negedge clk); put(1, 0, 0, 2, 1, 1); #1;
    @(negedge clk); put(1, 2, 2, 5, 1, 0); hz.Branch_Taken = 1'b1; #1;
    tests++; if (hz.Flush_ID !== 1'b1) begin fails++; $display("FAIL br_flush: got %b want 1", hz.Flush_ID); end
    tests++; if (hz.Stall !== 1'b0) begin fails++; $display("FAIL br_stall: got %b want 0", hz.Stall); end
    @(negedge clk); put(1, 5, 0, 6, 1, 0); hz.Branch_Taken = 1'b0; #1;
    tests++; if (hz.Stall !== 1'b0) begin fails++; $display("FAIL br_bubble: got %b want 0", hz.Stall); end
    tests++; if (hz.Forward_A !== 2'b00) begin fails++; $display("FAIL br_fwda: got %b want 00", hz.Forward_A); end
    tests++; if (hz.Stall_Cycles !== 16'd0) begin fails++; $display("FAIL br_cnt: got %0d want 0", hz.Stall_Cycles); end
  endtask

  task automatic test_r0();
    do_reset();
    @(negedge clk); put(1, 1, 1, 0, 1, 0); #1;
    @(negedge clk); put(1, 0, 0, 4, 1, 0); #1;
    tests++; if (hz.Stall !== 1'b0) begin fails++; $display("FAIL r0_stall: got %b want 0", hz.Stall); end
    @(negedge clk); put(0, 0, 0, 0, 0, 0); #1;
    tests++; if (hz.Forward_A !== 2'b00) begin fails++; $display("FAIL r0_fwda: got %b want 00", hz.Forward_A); end
    tests++; if (hz.Forward_B !== 2'b00) begin fails++; $display("FAIL r0_fwdb: got %b want 00", hz.Forward_B); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    @(negedge clk); put(1, 0, 0, 2, 1, 1); #1;
    @(negedge clk); put(0, 0, 0, 0, 0, 0); #1;
    @(negedge clk); hz.Mem_Ready = 1'b0; #1;
    tests++; if (hz.Freeze !== 1'b1) begin fails++; $display("FAIL rw_frz: got %b want 1", hz.Freeze); end
    @(negedge clk); #1;
    tests++; if (hz.Stall_Cycles !== 16'd1) begin fails++; $display("FAIL rw_cnt: got %0d want 1", hz.Stall_Cycles); end
    reset = 1'b1; #1;
    tests++; if (hz.Freeze !== 1'b0) begin fails++; $display("FAIL rw_frz0: got %b want 0", hz.Freeze); end
    tests++; if (hz.Stall_Cycles !== 16'd0) begin fails++; $display("FAIL rw_cnt0: got %0d want 0", hz.Stall_Cycles); end
    tests++; if (hz.Forward_A !== 2'b00) begin fails++; $display("FAIL rw_fwda: got %b want 00", hz.Forward_A); end
    tests++; if (hz.Forward_B !== 2'b00) begin fails++; $display("FAIL rw_fwdb: got %b want 00", hz.Forward_B); end
    @(negedge clk); reset = 1'b0; put(1, 2, 2, 5, 1, 0); #1;
    tests++; if (hz.Freeze !== 1'b0) begin fails++; $display("FAIL rw_frz_rel: got %b want 0", hz.Freeze); end
    tests++; if (hz.Stall !== 1'b0) begin fails++; $display("FAIL rw_stall_rel: got %b want 0", hz.Stall); end
    hz.Mem_Ready = 1'b1;
  endtask

  // Age of the youngest in-flight writer of src: 1 = EX, 2 = MEM, 0 = none
  function automatic int age(rec_t p0, rec_t p1, int src);
    if (src == 0) return 0;
    if (p0.v && p0.rw && p0.rd == src) return 1;
    if (p1.v && p1.rw && p1.rd == src) return 2;
    return 0;
  endfunction

  task automatic test_random();
    rec_t pipe[$];
    rec_t r;
    int cnt, da, db, rs1, rs2, rd;
    bit v, rw, mr, br, rdy, frz, stl, fl, ent;
    logic [1:0] ea, eb, na, nb;
    do_reset();
    pipe = {};
    for (int i = 0; i < 3; i++) begin
      r = '{default: 0};
      pipe.push_back(r);
    end
    cnt = 0;
    ea = 2'b00;
    eb = 2'b00;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      v   = $urandom_range(0, 9) < 8;
      rs1 = $urandom_range(0, 3);
      rs2 = $urandom_range(0, 3);
      rd  = $urandom_range(0, 3);
      mr  = $urandom_range(0, 3) == 0;
      rw  = mr || ($urandom_range(0, 9) < 7);
      br  = $urandom_range(0, 9) == 0;
      rdy = $urandom_range(0, 3) != 0;
      put(v, rs1, rs2, rd, rw, mr);
      hz.Branch_Taken = br;
      hz.Mem_Ready    = rdy;
      #1;
      da  = age(pipe[0], pipe[1], rs1);
      db  = age(pipe[0], pipe[1], rs2);
      frz = pipe[1].v && pipe[1].mr && !rdy;
      if (FWD) stl = v && pipe[0].mr && (da == 1 || db == 1);
      else     stl = v && (da != 0 || db != 0);
      stl = stl && !br && !frz;
      fl  = br && !frz;
      ent = v && !stl && !fl;
      na  = (FWD && ent) ? 2'(da) : 2'b00;
      nb  = (FWD && ent) ? 2'(db) : 2'b00;
      tests++; if (hz.Freeze !== frz) begin fails++; $display("FAIL rnd_frz c%0d: got %b want %b", cyc, hz.Freeze, frz); end
      tests++; if (hz.Stall !== stl) begin fails++; $display("FAIL rnd_stall c%0d: got %b want %b", cyc, hz.Stall, stl); end
      tests++; if (hz.Flush_ID !== fl) begin fails++; $display("FAIL rnd_flush c%0d: got %b want %b", cyc, hz.Flush_ID, fl); end
      tests++; if (hz.Forward_A !== ea) begin fails++; $display("FAIL rnd_fwda c%0d: got %b want %b", cyc, hz.Forward_A, ea); end
      tests++; if (hz.Forward_B !== eb) begin fails++; $display("FAIL rnd_fwdb c%0d: got %b want %b", cyc, hz.Forward_B, eb); end
      tests++; if (hz.Stall_Cycles !== 16'(cnt)) begin fails++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", cyc, hz.Stall_Cycles, cnt); end
      @(posedge clk);
      if ((stl || frz) && cnt < 65535) cnt++;
      if (!frz) begin
        ea = na;
        eb = nb;
        r = '{default: 0};
        if (ent) r = '{v: 1'b1, rd: rd, rw: rw, mr: mr};
        pipe.push_front(r);
        void'(pipe.pop_back());
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_mem_wait();
    test_branch_on_stall();
    test_r0();
    test_reset_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
